// File: rtl/csa_column_accumulator_if.sv
// Beat/result bus of the column accumulator: a 7:3 counter-bank beat goes in,
// one packet total comes out.
interface csa_column_accumulator_if #(
    parameter int W     = 8,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
);
    // Handshake: a beat or result moves only on a clock edge where valid && ready.
    // The producer holds valid and its payload stable until that edge.
    // ready never depends combinationally on valid.
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic [W-1:0]     in_carry;
    logic [W-1:0]     in_cout;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_overflow
    );
endinterface

// File: rtl/csa_column_accumulator.sv
// Merges sum/carry/cout column vectors with a registered 3:2 stage and folds
// every beat of a packet into a wide accumulator, one result per packet.
module csa_column_accumulator #(
    parameter int W     = 8,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    csa_column_accumulator_if.slave  bus
);
    localparam int VW  = W + 3;
    localparam int PAD = ACC_W + 1 - VW;

    logic [VW-1:0]    w_a, w_b, w_c, w_maj, w_ps, w_pc;
    logic [VW-1:0]    r_s1_ps, r_s1_pc;
    logic             r_s1_valid, r_s1_last;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pend;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_overflow;
    logic             w_blocked, w_fire, w_in_ready, w_in_xfer, w_out_xfer;
    logic [ACC_W:0]   w_acc_next;
    logic             w_carry;
    logic [CNT_W-1:0] w_cnt_next;

    // Align the three weighted vectors, then a plain full-adder row.
    assign w_a   = VW'(bus.in_sum);
    assign w_b   = VW'({bus.in_carry, 1'b0});
    assign w_c   = VW'({bus.in_cout, 2'b00});
    assign w_ps  = w_a ^ w_b ^ w_c;
    assign w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    assign w_pc  = w_maj << 1;

    // Only a last beat can stall, and only against a result not yet taken.
    assign w_blocked  = r_s1_last && r_out_valid && !bus.out_ready;
    assign w_fire     = r_s1_valid && !w_blocked;
    assign w_in_ready = !r_s1_valid || w_fire;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    assign w_acc_next = {1'b0, r_acc} + {{PAD{1'b0}}, r_s1_ps} + {{PAD{1'b0}}, r_s1_pc};
    assign w_carry    = w_acc_next[ACC_W];
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_ps    <= '0;
            r_s1_pc    <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= bus.in_last;
            r_s1_ps    <= w_ps;
            r_s1_pc    <= w_pc;
        end else if (w_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_fire) begin
            if (r_s1_last) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf_pend <= 1'b0;
            end else begin
                r_acc      <= w_acc_next[ACC_W-1:0];
                r_cnt      <= w_cnt_next;
                r_ovf_pend <= r_ovf_pend | w_carry;
            end
        end
    end

    // A freshly loaded result takes priority over clearing the consumed one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_fire && r_s1_last) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_acc_next[ACC_W-1:0];
            r_out_count    <= w_cnt_next;
            r_out_overflow <= r_ovf_pend | w_carry;
        end else if (w_out_xfer) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_count    = r_out_count;
    assign bus.out_overflow = r_out_overflow;
endmodule

// File: tb/tb_csa_column_accumulator.sv
// Bench: a 20-bit and a 12-bit accumulator share one stimulus stream; packet
// totals from a reference model are queued on the last beat and checked on output.
module tb_csa_column_accumulator;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_sum, in_carry, in_cout;
    logic       in_last;
    logic       out_ready;
    int         ready_mode;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    // {count[8], data20[20], ovf20, data12[12], ovf12}
    logic [41:0] exp_q[$];
    longint      m_total;
    int          m_cnt;
    logic        stall_prev;
    logic [19:0] held_data;
    logic [7:0]  held_count;

    csa_column_accumulator_if #(.W(8), .ACC_W(20), .CNT_W(8)) bus_a ();
    csa_column_accumulator_if #(.W(8), .ACC_W(12), .CNT_W(8)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_sum    = in_sum;
    assign bus_a.in_carry  = in_carry;
    assign bus_a.in_cout   = in_cout;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_sum    = in_sum;
    assign bus_b.in_carry  = in_carry;
    assign bus_b.in_cout   = in_cout;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    csa_column_accumulator #(.W(8), .ACC_W(20), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    csa_column_accumulator #(.W(8), .ACC_W(12), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // scoreboard / monitor: values at the falling edge are what the next rising edge transfers
    always @(negedge clk) begin
        if (reset) begin
            m_total    = 0;
            m_cnt      = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", bus_a.out_data, held_data);
                check("hold_count", bus_a.out_count, held_count);
            end
            if (in_valid && bus_a.in_ready) begin
                m_total += longint'(in_sum) + 2 * longint'(in_carry) + 4 * longint'(in_cout);
                m_cnt++;
                if (in_last) begin
                    exp_q.push_back({(m_cnt > 255) ? 8'd255 : 8'(m_cnt),
                                     20'(m_total), 1'(m_total >= 64'd1048576),
                                     12'(m_total), 1'(m_total >= 64'd4096)});
                    m_total = 0;
                    m_cnt   = 0;
                end
            end
            if (bus_a.out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [41:0] e;
                    e = exp_q.pop_front();
                    check("count", bus_a.out_count, e[41:34]);
                    check("data20", bus_a.out_data, e[33:14]);
                    check("ovf20", bus_a.out_overflow, e[13]);
                    check("valid12", bus_b.out_valid, 1);
                    check("data12", bus_b.out_data, e[12:1]);
                    check("ovf12", bus_b.out_overflow, e[0]);
                end
            end
            stall_prev = bus_a.out_valid && !out_ready;
            held_data  = bus_a.out_data;
            held_count = bus_a.out_count;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] s, input logic [7:0] c, input logic [7:0] co,
                             input logic last);
        int k;
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_cout  = co;
        in_last  = last;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_a.in_ready && k < 5000);
        if (k >= 5000) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus_a.out_valid) && k < 5000) begin
            tick(1);
            k++;
        end
        if (k >= 5000) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_out_count", bus_a.out_count, 0);
        check("rst_out_ovf", bus_a.out_overflow, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", bus_a.in_ready, 1);
        tick(1);
    endtask

    initial begin
        int n0, len;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sum     = '0;
        in_carry   = '0;
        in_cout    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        ready_mode = 0;
        tick(2);
        do_reset();

        // single beat V=7, latency and held result
        send_beat(8'h01, 8'h01, 8'h01, 1'b1);
        @(negedge clk);
        check("lat_not_yet", bus_a.out_valid, 0);
        @(negedge clk);
        check("lat_valid", bus_a.out_valid, 1);
        check("lat_data", bus_a.out_data, 7);
        check("lat_count", bus_a.out_count, 1);
        tick(1);
        ready_mode = 1;
        wait_drain();

        // 4 beats of 1785 with downstream always ready
        tick(2);
        n0 = n_out;
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'hFF, 8'hFF, i == 3);
        wait_drain();
        tick(3);
        check("one_pulse", n_out - n0, 1);

        // back-to-back single-beat packets against a stalled output
        ready_mode = 0;
        tick(2);
        send_beat(8'h01, 8'h01, 8'h01, 1'b1);
        send_beat(8'h10, 8'h00, 8'h00, 1'b1);
        tick(3);
        check("stall_in_ready", bus_a.in_ready, 0);
        check("stall_data", bus_a.out_data, 7);
        ready_mode = 1;
        wait_drain();

        // 12-bit instance wraps 3*1785, next packet starts clean
        for (int i = 0; i < 3; i++) send_beat(8'hFF, 8'hFF, 8'hFF, i == 2);
        send_beat(8'h01, 8'h01, 8'h01, 1'b1);
        wait_drain();

        // reset in the middle of a packet drops the partial sum
        send_beat(8'hFF, 8'hFF, 8'hFF, 1'b0);
        send_beat(8'hFF, 8'hFF, 8'hFF, 1'b0);
        do_reset();
        send_beat(8'h05, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_data", bus_a.out_data, 5);
        check("post_rst_count", bus_a.out_count, 1);
        wait_drain();

        // random packets with throttled valid and ready
        ready_mode = 2;
        for (int p = 0; p < 400; p++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
                send_beat(8'($urandom), 8'($urandom), 8'($urandom), b == len - 1);
            end
        end
        wait_drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
